// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and types for the sequential Booth multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the {current bit, previous bit} pair.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration over the
// {upper(WIDTH+1), lower(WIDTH), booth bit} accumulator.
module booth_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH+1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH+1:0] next_acc
);

    booth_op_t        op;
    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   sum;

    // Add/subtract the multiplicand into the upper field, then shift right arithmetically.
    always_comb begin
        op        = booth_decode(acc[1:0]);
        upper     = acc[2*WIDTH+1:WIDTH+1];
        mcand_ext = {mcand[WIDTH-1], mcand};
        case (op)
            OP_ADD:  sum = upper + mcand_ext;
            OP_SUB:  sum = upper - mcand_ext;
            default: sum = upper;
        endcase
        next_acc = {sum[WIDTH], sum, acc[WIDTH:1]};
    end

endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth multiplier, one step per clock,
// WIDTH+1 cycles start-to-ready. Optional macro MULT_ZERO_SKIP_EN finishes a
// start with a zero operand in a single cycle.
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned ACC_W = 2*WIDTH + 2;
    localparam int unsigned CW    = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_step;
    logic [WIDTH-1:0] mcand;
    logic             last_step;
    logic             exc_step;
    logic             skip;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .next_acc (acc_step)
    );

    // Final-step detection, overflow of the finished product, optional zero skip.
    always_comb begin
        last_step = (state == ST_BUSY) && (count == CW'(WIDTH - 1));
        exc_step  = (acc_step[ACC_W-1:WIDTH+1] != {(WIDTH+1){acc_step[WIDTH]}});
`ifdef MULT_ZERO_SKIP_EN
        // Only from IDLE: a skip restart from DONE would make ready high twice in a row.
        skip = (state == ST_IDLE) &&
               ((data_operandA == '0) || (data_operandB == '0));
`else
        skip = 1'b0;
`endif
    end

    // FSM, iteration counter, accumulator and registered result outputs.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state          <= ST_IDLE;
            count          <= '0;
            acc            <= '0;
            mcand          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (ctrl_MULT) begin
                        mcand <= data_operandA;
                        acc   <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
                        count <= '0;
                        if (skip) begin
                            state          <= ST_DONE;
                            data_result    <= '0;
                            data_exception <= 1'b0;
                            data_resultRDY <= 1'b1;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (last_step) begin
                        // Results are taken from the final step's output so they are valid in DONE.
                        state          <= ST_DONE;
                        data_result    <= acc_step[WIDTH:1];
                        data_exception <= exc_step;
                        data_resultRDY <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed and random checks of booth_multiplier against
// a plain signed-arithmetic reference.
module tb_booth_multiplier;

    localparam int unsigned W = 32;
`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         ctrl_reset_n = 1'b0;
    logic         ctrl_MULT = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;

    int checks = 0;
    int passes = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: full signed product, low W bits, overflow if not representable.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint       p;
        logic [W-1:0] lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[W-1:0];
        return {(p != longint'($signed(lo))), lo};
    endfunction

    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        if (ZSKIP && (a == '0 || b == '0)) return 1;
        return W + 1;
    endfunction

    // Called at a negedge; returns at the first negedge after the start edge.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
    endtask

    // n counts start-edge-relative edges at which a downstream stage sees ready.
    task automatic wait_rdy(output int n);
        n = 1;
        while (!data_resultRDY && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int         n;
        logic [W:0] m;
        m = model(a, b);
        drive_start(a, b);
        wait_rdy(n);
        check({tag, " latency"}, n, exp_latency(a, b));
        check({tag, " result"}, data_result, m[W-1:0]);
        check({tag, " exception"}, data_exception, m[W]);
        @(negedge clock);
        check({tag, " rdy one cycle"}, data_resultRDY, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        check({tag, " result held"}, data_result, m[W-1:0]);
        check({tag, " exception held"}, data_exception, m[W]);
    endtask

    initial begin
        int          n;
        int          rdy_seen;
        logic [W:0]  m;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset held while a start is requested: reset wins.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        repeat (3) @(negedge clock);
        check("reset result", data_result, '0);
        check("reset exception", data_exception, 1'b0);
        check("reset rdy", data_resultRDY, 1'b0);
        ctrl_MULT    = 1'b0;
        ctrl_reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle after reset rdy", data_resultRDY, 1'b0);

        do_op(32'd3, 32'd4, "3x4");
        do_op(-32'sd7, 32'd5, "-7x5");
        do_op(32'h8000_0000, 32'd1, "min x 1");
        do_op(32'h7FFF_FFFF, 32'd2, "max x 2");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, "min x -1");

        // Start pulse during BUSY must be ignored.
        drive_start(32'd6, 32'd7);
        n = 1;
        while (!data_resultRDY && n < 100) begin
            @(negedge clock);
            n++;
            if (n == 10) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'd1;
                data_operandB = 32'd1;
            end else begin
                ctrl_MULT = 1'b0;
            end
        end
        check("6x7 busy pulse latency", n, W + 1);
        check("6x7 busy pulse result", data_result, 32'd42);
        check("6x7 busy pulse exception", data_exception, 1'b0);
        // Restart in the DONE cycle.
        do_op(32'd2, 32'd2, "b2b 2x2");

        // Reset mid-operation aborts without a ready strobe.
        drive_start(32'd9, 32'd9);
        repeat (14) @(negedge clock);
        ctrl_reset_n = 1'b0;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        check("abort result", data_result, '0);
        check("abort exception", data_exception, 1'b0);
        check("abort rdy", data_resultRDY, 1'b0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("abort no rdy", rdy_seen, 0);
        do_op(32'd9, 32'd9, "9x9 after reset");

        do_op(32'd0, 32'd12345, "0x12345");
        do_op(32'd12345, 32'd0, "12345x0");

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = $urandom_range(0, 255);
            if (i % 4 == 2) a = -$urandom_range(1, 255);
            do_op(a, b, $sformatf("rand%0d", i));
        end

        // Back-to-back random pair: restart exactly in the ready cycle.
        a = $urandom;
        b = $urandom;
        drive_start(a, b);
        wait_rdy(n);
        m = model(a, b);
        check("b2b rand first result", data_result, m[W-1:0]);
        do_op(b, a, "b2b rand second");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
